// File: rtl/ser_word_aligner_pkg.sv
// Shared types and helpers for the serial word aligner.
//   state_e   : aligner FSM state encoding
//   SAT_W     : width of the saturating comma/miss counters (holds 1..15)
//   cnt_width : bit-counter width for a given word width
//   sat_inc   : saturating increment for the comma/miss counters
package ser_word_aligner_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int unsigned SAT_W = 4;
  localparam logic [SAT_W-1:0] SAT_MAX = '1;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? int'($clog2(width)) : 1;
  endfunction

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    return (v == SAT_MAX) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/ser_shift_window.sv
// Input conditioning, shift register and comma window comparator.
//   CK, CDN   : clock, async active-low reset
//   D         : serial line
//   sr_next_c : shift register contents after this edge's bit (comb)
//   match_c   : sr_next_c equals the comma pattern (comb)
module ser_shift_window #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] COMMA  = 8'hBC,
  parameter bit               INV_IN = 1'b0
) (
  input  logic             CK,
  input  logic             CDN,
  input  logic             D,
  output logic [WIDTH-1:0] sr_next_c,
  output logic             match_c
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic             d_c;

  // Newest bit enters at the LSB, so the first-received bit ends at the MSB.
  always_comb begin
    d_c       = D ^ INV_IN;
    sr_next_c = {sr_q[WIDTH-2:0], d_c};
    match_c   = (sr_next_c == COMMA);
    sr_d      = sr_next_c;
  end

  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) sr_q <= '0;
    else      sr_q <= sr_d;
  end

endmodule

// File: rtl/ser_word_aligner.sv
// Serial-to-parallel receiver with comma-based word alignment.
//   CK, CDN : clock, async active-low reset
//   D       : serial data, one bit per rising edge
//   BITSLIP : delay word boundary by one bit (ignored while locked)
//   Q       : received word, first-received bit at Q[WIDTH-1]
//   QVALID  : one-cycle strobe, Q updated this cycle
//   LOCKED  : word alignment confirmed
module ser_word_aligner
  import ser_word_aligner_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] COMMA    = 8'hBC,
  parameter bit               INV_IN   = 1'b0,
  parameter int unsigned      LOCK_CNT = 3,
  parameter int unsigned      MISS_MAX = 2
) (
  input  logic             CK,
  input  logic             CDN,
  input  logic             D,
  input  logic             BITSLIP,
  output logic [WIDTH-1:0] Q,
  output logic             QVALID,
  output logic             LOCKED
);

  localparam int unsigned      CNT_W  = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH - 1);
  localparam logic [SAT_W-1:0] LOCK_N = SAT_W'(LOCK_CNT);
  localparam logic [SAT_W-1:0] MISS_N = SAT_W'(MISS_MAX);

  logic [WIDTH-1:0] sr_next_c;
  logic             match_c;

  ser_shift_window #(
    .WIDTH  (WIDTH),
    .COMMA  (COMMA),
    .INV_IN (INV_IN)
  ) u_window (
    .CK        (CK),
    .CDN       (CDN),
    .D         (D),
    .sr_next_c (sr_next_c),
    .match_c   (match_c)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SAT_W-1:0] comma_cnt_q, comma_cnt_d;
  logic [SAT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qvalid_q, qvalid_d;
  logic             locked_q, locked_d;
  logic             boundary_c;
  logic             emit_c;
  logic             realign_c;

  // Next-state, framing and output logic.
  always_comb begin
    boundary_c  = (cnt_q == CNT_END);
    state_d     = state_q;
    cnt_d       = boundary_c ? '0 : cnt_q + CNT_W'(1);
    comma_cnt_d = comma_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    q_d         = q_q;
    qvalid_d    = 1'b0;
    locked_d    = locked_q;
    emit_c      = boundary_c;
    realign_c   = 1'b0;

    unique case (state_q)
      ST_HUNT, ST_CONFIRM: begin
        // A comma wins over BITSLIP; an off-boundary comma re-frames.
        if (match_c && ((state_q == ST_HUNT) || !boundary_c)) begin
          realign_c = 1'b1;
        end else if (match_c) begin
          comma_cnt_d = sat_inc(comma_cnt_q);
          if (comma_cnt_d >= LOCK_N) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end
        end else if (BITSLIP) begin
          cnt_d = cnt_q;
        end
      end
      ST_LOCKED: begin
        // Framing is frozen here; commas only feed the miss counter.
        if (match_c && boundary_c) begin
          miss_cnt_d = '0;
        end else if (match_c) begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          if (miss_cnt_d >= MISS_N) begin
            state_d     = ST_HUNT;
            locked_d    = 1'b0;
            comma_cnt_d = '0;
            miss_cnt_d  = '0;
          end
        end
      end
      default: begin
        state_d  = ST_HUNT;
        locked_d = 1'b0;
      end
    endcase

    if (realign_c) begin
      cnt_d       = '0;
      emit_c      = 1'b1;
      comma_cnt_d = SAT_W'(1);
      if (LOCK_N <= SAT_W'(1)) begin
        state_d  = ST_LOCKED;
        locked_d = 1'b1;
      end else begin
        state_d  = ST_CONFIRM;
      end
    end

    if (emit_c) begin
      q_d      = sr_next_c;
      qvalid_d = 1'b1;
    end
  end

  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      state_q     <= ST_HUNT;
      cnt_q       <= '0;
      comma_cnt_q <= '0;
      miss_cnt_q  <= '0;
      q_q         <= '0;
      qvalid_q    <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      comma_cnt_q <= comma_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      q_q         <= q_d;
      qvalid_q    <= qvalid_d;
      locked_q    <= locked_d;
    end
  end

  assign Q      = q_q;
  assign QVALID = qvalid_q;
  assign LOCKED = locked_q;

endmodule

// File: tb/tb_ser_word_aligner.sv
// Self-checking bench for ser_word_aligner: a plain and an inverting
// instance see complementary lines and must both match one reference model.
module tb_ser_word_aligner;

  localparam int unsigned W        = 8;
  localparam logic [7:0]  COMMA    = 8'hBC;
  localparam int unsigned LOCK_CNT = 3;
  localparam int unsigned MISS_MAX = 2;

  logic       CK = 1'b0;
  logic       CDN = 1'b0;
  logic       d_in = 1'b0;
  logic       d_inv;
  logic       bitslip = 1'b0;
  logic [7:0] q0, q1;
  logic       qv0, qv1, lk0, lk1;

  assign d_inv = ~d_in;

  always #5 CK = ~CK;

  ser_word_aligner #(.WIDTH(W), .COMMA(COMMA), .INV_IN(1'b0),
                     .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) u_dut (
    .CK(CK), .CDN(CDN), .D(d_in), .BITSLIP(bitslip),
    .Q(q0), .QVALID(qv0), .LOCKED(lk0));

  ser_word_aligner #(.WIDTH(W), .COMMA(COMMA), .INV_IN(1'b1),
                     .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) u_inv (
    .CK(CK), .CDN(CDN), .D(d_inv), .BITSLIP(bitslip),
    .Q(q1), .QVALID(qv1), .LOCKED(lk1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a bit history window, a position within the word and a
  // mode number (0 hunt, 1 confirm, 2 locked), stepped by the stated rules.
  int unsigned m_win;
  int          m_pos, m_mode, m_commas, m_misses;
  logic [7:0]  m_q;
  logic        m_qv, m_lk;

  task automatic m_reset();
    m_win = 0; m_pos = 0; m_mode = 0; m_commas = 0; m_misses = 0;
    m_q = '0; m_qv = 1'b0; m_lk = 1'b0;
  endtask

  task automatic m_step(input logic d, input logic slip);
    bit hit, at_end, take;
    int nxt;
    m_win  = ((m_win << 1) | 32'(d)) % 256;
    hit    = (m_win == 32'(COMMA));
    at_end = (m_pos == W - 1);
    take   = at_end;
    nxt    = (m_pos + 1) % W;
    if (m_mode == 2) begin
      if (hit && at_end) m_misses = 0;
      else if (hit) begin
        m_misses = (m_misses < 15) ? m_misses + 1 : 15;
        if (m_misses >= MISS_MAX) begin
          m_mode = 0; m_commas = 0; m_misses = 0;
        end
      end
    end else if (hit && m_mode == 1 && at_end) begin
      m_commas = (m_commas < 15) ? m_commas + 1 : 15;
      if (m_commas >= LOCK_CNT) m_mode = 2;
    end else if (hit) begin
      nxt = 0; take = 1'b1; m_commas = 1;
      m_mode = (LOCK_CNT == 1) ? 2 : 1;
    end else if (slip) begin
      nxt = m_pos;
    end
    m_pos = nxt;
    m_qv  = take;
    if (take) m_q = m_win[7:0];
    m_lk  = (m_mode == 2);
  endtask

  // One bit on the line, then compare both instances against the model.
  task automatic step(input logic d, input logic slip);
    d_in = d; bitslip = slip;
    @(posedge CK); #1;
    m_step(d, slip);
    check("q",       16'(q0),  16'(m_q));
    check("qvalid",  16'(qv0), 16'(m_qv));
    check("locked",  16'(lk0), 16'(m_lk));
    check("inv_q",      16'(q1),  16'(m_q));
    check("inv_qvalid", 16'(qv1), 16'(m_qv));
    check("inv_locked", 16'(lk1), 16'(m_lk));
    bitslip = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int slip_at);
    for (int b = 0; b < 8; b++) step(w[7-b], (b == slip_at) ? 1'b1 : 1'b0);
  endtask

  task automatic do_reset();
    CDN = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      d_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(posedge CK); #1;
      check("rst_q",      16'(q0),  16'h0);
      check("rst_qvalid", 16'(qv0), 16'h0);
      check("rst_locked", 16'(lk0), 16'h0);
    end
    CDN = 1'b1;
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_q;
    logic       exp_qv;
    logic       exp_lk;
  } vec_t;

  vec_t vecs[8];
  int   qpos[$];
  int   exp_pos[4];
  int   nqv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hBC, 8'hBC, 1'b1, 1'b0};
    vecs[1] = '{8'hBC, 8'hBC, 1'b1, 1'b0};
    vecs[2] = '{8'hBC, 8'hBC, 1'b1, 1'b1};
    vecs[3] = '{8'h5A, 8'h5A, 1'b1, 1'b1};
    vecs[4] = '{8'h12, 8'h12, 1'b1, 1'b1};
    vecs[5] = '{8'hC3, 8'hC3, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'hA5, 8'hA5, 1'b1, 1'b1};
    exp_pos = '{8, 17, 25, 33};

    #2;
    do_reset();

    // Alignment after three junk bits, then framed data.
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    foreach (vecs[i]) begin
      send_word(vecs[i].word, -1);
      check("tbl_q",      16'(q0),  16'(vecs[i].exp_q));
      check("tbl_qvalid", 16'(qv0), 16'(vecs[i].exp_qv));
      check("tbl_locked", 16'(lk0), 16'(vecs[i].exp_lk));
      check("tbl_inv_q",  16'(q1),  16'(vecs[i].exp_q));
    end

    // BITSLIP in HUNT stretches one strobe interval to 9.
    do_reset();
    qpos.delete();
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, (k == 12) ? 1'b1 : 1'b0);
      if (qv0) qpos.push_back(k);
    end
    check("slip_count", 16'(qpos.size()), 16'd4);
    for (int i = 0; i < 4; i++)
      check("slip_pos", (qpos.size() > i) ? 16'(qpos[i]) : 16'hFFFF, 16'(exp_pos[i]));

    // BITSLIP while LOCKED leaves framing alone.
    for (int i = 0; i < 3; i++) send_word(COMMA, -1);
    check("lock_before_slip", 16'(lk0), 16'd1);
    nqv = 0;
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < 8; b++) begin
        step(1'b0, (i == 0 && b == 3) ? 1'b1 : 1'b0);
        if (qv0) nqv++;
      end
      check("locked_slip_qv", 16'(qv0), 16'd1);
    end
    check("locked_slip_count", 16'(nqv), 16'd3);

    // Two commas shifted by three bits drop lock on the second one.
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) step(1'b0, 1'b0);
      for (int b = 0; b < 8; b++) step(COMMA[7-b], 1'b0);
      check("miss_locked", 16'(lk0), (p == 0) ? 16'd1 : 16'd0);
      for (int b = 0; b < 5; b++) step(1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      send_word(COMMA, -1);
      check("relock", 16'(lk0), (i == 2) ? 16'd1 : 16'd0);
    end

    // Async reset four bits into a locked word.
    for (int b = 0; b < 4; b++) step(1'b0, 1'b0);
    CDN = 1'b0;
    #1;
    check("midrst_q",      16'(q0),  16'h0);
    check("midrst_qvalid", 16'(qv0), 16'h0);
    check("midrst_locked", 16'(lk0), 16'h0);
    check("midrst_inv_locked", 16'(lk1), 16'h0);
    m_reset();
    @(posedge CK); #1;
    CDN = 1'b1;
    for (int b = 0; b < 4; b++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_word(COMMA, -1);
      check("midrst_relock", 16'(lk0), (i == 2) ? 16'd1 : 16'd0);
    end

    // Random line data with injected commas and sporadic BITSLIP.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 9) == 0) send_word(COMMA, -1);
      else step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
